// File: rtl/fd_inst_queue.sv
// rtl/fd_inst_queue.sv - fetch-to-decode instruction queue pairing fetch metadata with SRAM replies
module fd_inst_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h03400000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        f_req,
    input  logic [31:0] f_pc,
    input  logic        f_ex,
    input  logic [7:0]  f_ecode,
    input  logic        f_esubcode,
    output logic        q_allowin,
    input  logic [31:0] inst_rdata,
    input  logic        flush,
    input  logic        d_allowin,
    output logic        d_valid,
    output logic [73:0] d_bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [73:0]   r_entry [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_pend_v;
    logic [31:0]   r_pend_pc;
    logic          r_pend_ex;
    logic [7:0]    r_pend_ecode;
    logic          r_pend_esub;
    logic          r_ex_lock;

    logic [CW:0]   w_occ;
    logic          w_push;
    logic          w_write;
    logic          w_pop;
    logic [73:0]   w_wdata;

    // Credit includes the reply still in flight so the queue can never overflow.
    assign w_occ     = {1'b0, r_count} + (CW+1)'(r_pend_v);
    assign q_allowin = ~r_ex_lock & (w_occ < (CW+1)'(DEPTH)) & ~flush;
    assign d_valid   = (r_count != '0);
    assign d_bus     = d_valid ? r_entry[r_head] : 74'd0;

    assign w_push  = f_req & q_allowin;
    assign w_write = r_pend_v & ~flush;
    assign w_pop   = d_valid & d_allowin & ~flush;
    assign w_wdata = {r_pend_pc, (r_pend_ex ? NOP : inst_rdata),
                      r_pend_ex, r_pend_ecode, r_pend_esub};

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_pend_v  <= 1'b0;
            r_ex_lock <= 1'b0;
        end else begin
            r_pend_v <= w_push;
            r_count  <= r_count + CW'(w_write) - CW'(w_pop);
            if (w_write) begin
                r_tail <= r_tail + 1'b1;
                if (r_pend_ex)
                    r_ex_lock <= 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
        end
    end

    // Payload storage needs no reset: validity is carried by r_pend_v and r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pend_pc    <= f_pc;
            r_pend_ex    <= f_ex;
            r_pend_ecode <= f_ecode;
            r_pend_esub  <= f_esubcode;
        end
        if (rstn && w_write)
            r_entry[r_tail] <= w_wdata;
    end
endmodule

// File: tb/tb_fd_inst_queue.sv
// tb/tb_fd_inst_queue.sv - self-checking bench for fd_inst_queue with a queue-based reference model
module tb_fd_inst_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h03400000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        f_req;
    logic [31:0] f_pc;
    logic        f_ex;
    logic [7:0]  f_ecode;
    logic        f_esubcode;
    logic        q_allowin;
    logic [31:0] inst_rdata;
    logic        flush;
    logic        d_allowin;
    logic        d_valid;
    logic [73:0] d_bus;

    int n_cmp = 0;
    int n_bad = 0;

    fd_inst_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk(clk), .rstn(rstn), .f_req(f_req), .f_pc(f_pc), .f_ex(f_ex),
        .f_ecode(f_ecode), .f_esubcode(f_esubcode), .q_allowin(q_allowin),
        .inst_rdata(inst_rdata), .flush(flush), .d_allowin(d_allowin),
        .d_valid(d_valid), .d_bus(d_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [73:0] got, input logic [73:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sram(input logic [31:0] a);
        if (a == 32'h1c000000)
            return 32'h02800c0c;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Reference model: list of queued entries plus one outstanding request.
    logic [73:0] mq[$];
    bit          mp_v, mp_ex, mp_es, mlock, model_ok;
    logic [31:0] mp_pc;
    logic [7:0]  mp_ec;

    always @(negedge clk) begin
        bit exp_allow, push;
        exp_allow = !mlock && ((mq.size() + int'(mp_v)) < DEPTH) && !flush;
        if (model_ok) begin
            chk("d_valid", {73'd0, d_valid}, {73'd0, mq.size() != 0});
            chk("q_allowin", {73'd0, q_allowin}, {73'd0, exp_allow});
            chk("d_bus", d_bus, (mq.size() != 0) ? mq[0] : 74'd0);
        end
        if (!rstn || (model_ok && flush)) begin
            mq.delete();
            mp_v = 0; mlock = 0; model_ok = 1;
        end else if (model_ok) begin
            push = f_req && exp_allow;
            if (mq.size() != 0 && d_allowin)
                void'(mq.pop_front());
            if (mp_v) begin
                mq.push_back({mp_pc, (mp_ex ? NOP : inst_rdata), mp_ex, mp_ec, mp_es});
                if (mp_ex) mlock = 1;
            end
            mp_v = push;
            if (push) begin
                mp_pc = f_pc; mp_ex = f_ex; mp_ec = f_ecode; mp_es = f_esubcode;
            end
        end
    end

    logic        prev_req;
    logic [31:0] prev_pc;

    task automatic tick();
        prev_req = f_req;
        prev_pc  = f_pc;
        @(posedge clk);
        #1;
        inst_rdata = prev_req ? sram(prev_pc) : 32'hdeadbeef;
    endtask

    initial begin
        int accepted;
        rstn = 0; f_req = 0; f_pc = 0; f_ex = 0; f_ecode = 0; f_esubcode = 0;
        inst_rdata = 0; flush = 0; d_allowin = 0;
        mp_v = 0; mlock = 0; model_ok = 0;
        tick(); tick();
        rstn = 1; #1;
        chk("rst_d_valid", {73'd0, d_valid}, 74'd0);
        chk("rst_q_allowin", {73'd0, q_allowin}, 74'd1);
        chk("rst_d_bus", d_bus, 74'd0);

        // single request latency
        f_req = 1; f_pc = 32'h1c000000; d_allowin = 1;
        tick(); f_req = 0; #1;
        chk("t1_not_yet", {73'd0, d_valid}, 74'd0);
        tick(); #1;
        chk("t1_d_valid", {73'd0, d_valid}, 74'd1);
        chk("t1_d_bus", d_bus, {32'h1c000000, 32'h02800c0c, 1'b0, 8'h00, 1'b0});
        tick(); #1;
        chk("t1_drained", {73'd0, d_valid}, 74'd0);

        // sustained back-to-back stream across pointer wrap
        for (int i = 0; i < 6; i++) begin
            f_req = 1; f_pc = 32'h1c000200 + 32'(4 * i); #1;
            chk("stream_allow", {73'd0, q_allowin}, 74'd1);
            tick();
        end
        f_req = 0;
        tick(); tick(); tick();

        // fill with decode stalled
        d_allowin = 0; accepted = 0;
        for (int c = 0; c < 8; c++) begin
            f_req = 1; f_pc = 32'h1c000100 + 32'(4 * accepted); #1;
            if (q_allowin) accepted++;
            tick();
        end
        f_req = 0; #1;
        chk("t2_accepted", 74'(accepted), 74'd4);
        chk("t2_full_valid", {73'd0, d_valid}, 74'd1);
        chk("t2_full_allow", {73'd0, q_allowin}, 74'd0);
        d_allowin = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_pc", {42'd0, d_bus[73:42]}, {42'd0, 32'h1c000100 + 32'(4 * i)});
            tick(); #1;
        end
        chk("t2_empty", {73'd0, d_valid}, 74'd0);

        // simultaneous write and pop at count 2
        d_allowin = 0;
        f_req = 1; f_pc = 32'h1c000300; tick();
        f_pc = 32'h1c000304; tick();
        f_pc = 32'h1c000308; tick();
        f_req = 0; d_allowin = 1; #1;
        chk("t5_head0", {42'd0, d_bus[73:42]}, {42'd0, 32'h1c000300});
        tick(); #1;
        chk("t5_head1", {42'd0, d_bus[73:42]}, {42'd0, 32'h1c000304});
        tick(); #1;
        chk("t5_head2", {42'd0, d_bus[73:42]}, {42'd0, 32'h1c000308});
        tick(); #1;
        chk("t5_empty", {73'd0, d_valid}, 74'd0);

        // faulting fetch locks the queue until flush
        d_allowin = 0;
        f_req = 1; f_pc = 32'h1c000010; f_ex = 1; f_ecode = 8'h08; f_esubcode = 0;
        tick();
        f_req = 0; f_ex = 0; f_ecode = 0;
        tick(); #1;
        chk("t3_valid", {73'd0, d_valid}, 74'd1);
        chk("t3_bus", d_bus, {32'h1c000010, 32'h03400000, 1'b1, 8'h08, 1'b0});
        chk("t3_lock", {73'd0, q_allowin}, 74'd0);
        f_req = 1; f_pc = 32'h1c000014;
        tick(); #1;
        chk("t3_lock2", {73'd0, q_allowin}, 74'd0);
        tick();
        f_req = 0; flush = 1; #1;
        chk("t3_flush_allow", {73'd0, q_allowin}, 74'd0);
        chk("t3_flush_valid", {73'd0, d_valid}, 74'd1);
        tick(); flush = 0; #1;
        chk("t3_after_valid", {73'd0, d_valid}, 74'd0);
        chk("t3_after_allow", {73'd0, q_allowin}, 74'd1);

        // flush with three entries queued and one reply in flight
        for (int i = 0; i < 4; i++) begin
            f_req = 1; f_pc = 32'h1c000400 + 32'(4 * i); tick();
        end
        f_req = 0; flush = 1; #1;
        chk("t4_pre_valid", {73'd0, d_valid}, 74'd1);
        chk("t4_pre_allow", {73'd0, q_allowin}, 74'd0);
        tick(); flush = 0; #1;
        chk("t4_valid", {73'd0, d_valid}, 74'd0);
        chk("t4_allow", {73'd0, q_allowin}, 74'd1);
        chk("t4_bus", d_bus, 74'd0);
        f_req = 1; f_pc = 32'h1c000500; tick();
        f_req = 0; tick(); #1;
        chk("t4_fresh", d_bus, {32'h1c000500, sram(32'h1c000500), 1'b0, 8'h00, 1'b0});
        d_allowin = 1; tick(); tick();

        // reset while full
        d_allowin = 0;
        for (int i = 0; i < 5; i++) begin
            f_req = 1; f_pc = 32'h1c000600 + 32'(4 * i); tick();
        end
        f_req = 0; #1;
        chk("t6_full_valid", {73'd0, d_valid}, 74'd1);
        chk("t6_full_allow", {73'd0, q_allowin}, 74'd0);
        rstn = 0; tick(); rstn = 1; #1;
        chk("t6_valid", {73'd0, d_valid}, 74'd0);
        chk("t6_allow", {73'd0, q_allowin}, 74'd1);
        chk("t6_bus", d_bus, 74'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
